// File: rtl/lockin_stream_pkg.sv
// Shared definitions for the lock-in result streaming path.
//   WORD_W            : stream word width in bits
//   state_t           : capture/serialise sequencer states
//   words_per_channel : number of stream words per channel result
package lockin_stream_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SER  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int words_per_channel(input int result_w);
    return result_w / WORD_W;
  endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous flush, overrides push and pop
//   push/din : write request (refused while full)
//   pop/dout : read request (ignored while empty); dout is the head word
//   empty, full, level : occupancy status, level counts 0..DEPTH
module sync_fwft_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_level == '0);
  assign full  = (r_level == LVL_W'(DEPTH));
  assign level = r_level;
  // Head word is forced to zero while empty so the output is defined after reset.
  assign dout  = empty ? '0 : r_mem[r_rd];

  // full is taken before any same-cycle pop, so a full buffer refuses a push.
  assign w_do_push = push && !full && !clear;
  assign w_do_pop  = pop && !empty && !clear;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/result_stream_packer.sv
// Captures a snapshot of N_CH result channels when any channel flags a valid
// result, serialises the flagged channels into 32-bit words (low word first,
// ascending channel order) into a FWFT buffer and drains it as a ready/valid
// stream.
//   clk, reset           : clock, asynchronous active-high reset
//   enable, clear        : capture enable, synchronous soft clear
//   frame_limit          : frames to capture before finishing (0 = unlimited)
//   res_data, res_valid  : channel results and per-channel valid strobes
//   out_data/valid/ready : output word stream
//   fifo_level           : words currently buffered
//   frames_done          : completed frames (saturating)
//   overflow             : sticky, a valid result was dropped
//   finished             : frame_limit reached
module result_stream_packer
  import lockin_stream_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int RESULT_W   = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic [CNT_W-1:0]             frame_limit,
  input  logic [N_CH*RESULT_W-1:0]     res_data,
  input  logic [N_CH-1:0]              res_valid,
  output logic [WORD_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [CNT_W-1:0]             frames_done,
  output logic                         overflow,
  output logic                         finished
);

  localparam int WPC  = words_per_channel(RESULT_W);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WD_W = (WPC > 1) ? $clog2(WPC) : 1;
  localparam logic [WD_W-1:0] LAST_WORD = WD_W'(WPC - 1);

  state_t            r_state;
  logic [WORD_W-1:0] r_snap [N_CH][WPC];
  logic [N_CH-1:0]   r_mask;
  logic [CH_W-1:0]   r_ch;
  logic [WD_W-1:0]   r_word;

  logic              w_any_valid;
  logic              w_capture;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic [WORD_W-1:0] w_din;
  logic [CH_W-1:0]   w_first_ch;
  logic [CH_W-1:0]   w_next_ch;
  logic              w_has_next;
  logic [CNT_W-1:0]  w_frames_inc;

  assign w_any_valid  = |res_valid;
  assign w_capture    = (r_state == IDLE) && enable && !finished && w_any_valid;
  assign w_drop       = (r_state != IDLE) && enable && !finished && w_any_valid;
  assign w_push       = (r_state == SER) && !w_full;
  assign w_pop        = out_valid && out_ready;
  assign w_din        = r_snap[r_ch][r_word];
  assign out_valid    = !w_empty;
  assign w_frames_inc = (&frames_done) ? frames_done : frames_done + 1'b1;

  // Lowest set valid bit selects the first channel of a new frame; scanning
  // downwards lets the last hit win.
  always_comb begin
    w_first_ch = '0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (res_valid[i-1]) w_first_ch = CH_W'(i - 1);
    end
  end

  // Next flagged channel strictly above the current one, found combinationally
  // so skipped channels cost no cycles.
  always_comb begin
    w_next_ch  = r_ch;
    w_has_next = 1'b0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (((i - 1) > 32'(r_ch)) && r_mask[i-1]) begin
        w_next_ch  = CH_W'(i - 1);
        w_has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_snap      <= '{default: '0};
      r_mask      <= '0;
      r_ch        <= '0;
      r_word      <= '0;
      frames_done <= '0;
      overflow    <= 1'b0;
      finished    <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_snap      <= '{default: '0};
      r_mask      <= '0;
      r_ch        <= '0;
      r_word      <= '0;
      frames_done <= '0;
      overflow    <= 1'b0;
      finished    <= 1'b0;
    end else begin
      if (w_drop) overflow <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            for (int unsigned c = 0; c < N_CH; c++) begin
              for (int unsigned w = 0; w < WPC; w++) begin
                r_snap[c][w] <= res_data[c*RESULT_W + w*WORD_W +: WORD_W];
              end
            end
            r_mask  <= res_valid;
            r_ch    <= w_first_ch;
            r_word  <= '0;
            r_state <= SER;
          end
        end
        SER: begin
          if (w_push) begin
            if (r_word == LAST_WORD) begin
              r_word <= '0;
              if (w_has_next) r_ch    <= w_next_ch;
              else            r_state <= DONE;
            end else begin
              r_word <= r_word + 1'b1;
            end
          end
        end
        DONE: begin
          frames_done <= w_frames_inc;
          if ((frame_limit != '0) && (w_frames_inc == frame_limit)) finished <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sync_fwft_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (out_data),
    .empty (w_empty),
    .full  (w_full),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_result_stream_packer.sv
module tb_result_stream_packer;

  localparam int N_CH     = 2;
  localparam int RESULT_W = 64;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 16;
  localparam int WPC      = RESULT_W / 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     enable;
  logic                     clear;
  logic [CNT_W-1:0]         frame_limit;
  logic [N_CH*RESULT_W-1:0] res_data;
  logic [N_CH-1:0]          res_valid;
  logic [31:0]              out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [3:0]               fifo_level;
  logic [CNT_W-1:0]         frames_done;
  logic                     overflow;
  logic                     finished;

  always #5 clk = ~clk;

  result_stream_packer #(
    .N_CH       (N_CH),
    .RESULT_W   (RESULT_W),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .frame_limit (frame_limit),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_level  (fifo_level),
    .frames_done (frames_done),
    .overflow    (overflow),
    .finished    (finished)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents, words still owed by the current frame,
  // one-cycle frame-completion marker, counters and flags.
  logic [31:0] fq[$];
  logic [31:0] pend[$];
  logic [31:0] got[$];
  bit          m_done;
  logic [15:0] m_frames;
  bit          m_fin;
  bit          m_ovf;

  typedef struct {
    logic [63:0]       c0;
    logic [63:0]       c1;
    logic [1:0]        v;
    int                n;
    logic [3:0][31:0]  w;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    pend.delete();
    m_done   = 0;
    m_frames = '0;
    m_fin    = 0;
    m_ovf    = 0;
  endtask

  // Applies the frame rules to the inputs present before the coming edge.
  task automatic model_step();
    logic [31:0] w;
    bit          do_push;
    bit          cond;
    if (clear) begin
      model_reset();
      return;
    end
    cond    = enable && !m_fin && (res_valid != '0);
    do_push = 0;
    w       = '0;
    if (m_done) begin
      if (cond) m_ovf = 1;
      if (m_frames != 16'hFFFF) m_frames = m_frames + 16'd1;
      if (frame_limit != 0 && m_frames == frame_limit) m_fin = 1;
      m_done = 0;
    end else if (pend.size() != 0) begin
      if (cond) m_ovf = 1;
      if (fq.size() < DEPTH) begin
        w       = pend.pop_front();
        do_push = 1;
        if (pend.size() == 0) m_done = 1;
      end
    end else if (cond) begin
      for (int c = 0; c < N_CH; c++)
        if (res_valid[c])
          for (int k = 0; k < WPC; k++)
            pend.push_back(res_data[c*RESULT_W + k*32 +: 32]);
    end
    if (out_ready && fq.size() != 0) void'(fq.pop_front());
    if (do_push) fq.push_back(w);
  endtask

  task automatic compare();
    chk("out_valid", out_valid, fq.size() != 0);
    if (fq.size() != 0) chk("out_data", out_data, fq[0]);
    chk("fifo_level", fifo_level, fq.size());
    chk("frames_done", frames_done, m_frames);
    chk("overflow", overflow, m_ovf);
    chk("finished", finished, m_fin);
  endtask

  task automatic cycle();
    if (out_valid && out_ready) got.push_back(out_data);
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic pulse(input logic [1:0] m, input logic [63:0] c0, input logic [63:0] c1);
    res_data  = {c1, c0};
    res_valid = m;
    cycle();
    res_valid = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    got.delete();
  endtask

  localparam logic [63:0] CH0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] CH1 = 64'hAAAA_BBBB_CCCC_DDDD;

  initial begin
    vecs[0].c0 = CH0; vecs[0].c1 = CH1; vecs[0].v = 2'b11; vecs[0].n = 4;
    vecs[0].w  = {32'hAAAABBBB, 32'hCCCCDDDD, 32'h11112222, 32'h33334444};
    vecs[1].c0 = CH0; vecs[1].c1 = CH1; vecs[1].v = 2'b10; vecs[1].n = 2;
    vecs[1].w  = {32'h0, 32'h0, 32'hAAAABBBB, 32'hCCCCDDDD};
    vecs[2].c0 = CH0; vecs[2].c1 = CH1; vecs[2].v = 2'b01; vecs[2].n = 2;
    vecs[2].w  = {32'h0, 32'h0, 32'h11112222, 32'h33334444};
    vecs[3].c0 = 64'hDEADBEEF_01234567; vecs[3].c1 = 64'h0; vecs[3].v = 2'b11; vecs[3].n = 4;
    vecs[3].w  = {32'h0, 32'h0, 32'hDEADBEEF, 32'h01234567};

    reset = 1'b1; enable = 1'b0; clear = 1'b0; frame_limit = '0;
    res_data = '0; res_valid = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_level", fifo_level, 0);
    chk("reset_frames", frames_done, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_finished", finished, 0);
    reset = 1'b0;
    cycle();

    // Table-driven frames with a free-running consumer.
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got.delete();
      pulse(vecs[i].v, vecs[i].c0, vecs[i].c1);
      chk("capture_no_valid_yet", out_valid, 0);
      cycle();
      chk("first_word_latency", out_valid, 1);
      repeat (8) cycle();
      chk("frame_word_count", got.size(), vecs[i].n);
      for (int k = 0; k < vecs[i].n && k < got.size(); k++)
        chk("frame_word", got[k], vecs[i].w[k]);
      chk("frame_count", frames_done, i + 1);
      chk("frame_overflow", overflow, 0);
    end

    // Frame limit of 3 with ten capture pulses.
    do_clear();
    frame_limit = 16'd3;
    for (int p = 0; p < 10; p++) begin
      pulse(2'b11, CH0, CH1);
      repeat (7) cycle();
    end
    repeat (4) cycle();
    chk("limit_words", got.size(), 12);
    chk("limit_finished", finished, 1);
    chk("limit_frames", frames_done, 3);
    chk("limit_overflow", overflow, 0);
    frame_limit = '0;

    // Back-pressure: fill the buffer, stall, then drain.
    do_clear();
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      pulse(2'b11, CH0, CH1);
      repeat (11) cycle();
    end
    chk("bp_level_full", fifo_level, 8);
    chk("bp_frames_stalled", frames_done, 2);
    out_ready = 1'b1;
    repeat (20) cycle();
    chk("bp_words", got.size(), 12);
    for (int k = 0; k < 12 && k < got.size(); k++)
      chk("bp_word", got[k], vecs[0].w[k % 4]);
    chk("bp_frames", frames_done, 3);
    chk("bp_overflow", overflow, 0);

    // Drop: second pulse while serialising.
    do_clear();
    pulse(2'b11, CH0, CH1);
    pulse(2'b01, CH1, CH0);
    repeat (8) cycle();
    chk("drop_overflow", overflow, 1);
    chk("drop_words", got.size(), 4);
    chk("drop_frames", frames_done, 1);
    repeat (5) cycle();
    chk("drop_sticky", overflow, 1);
    do_clear();
    chk("drop_cleared", overflow, 0);

    // Asynchronous reset in the middle of a frame.
    pulse(2'b11, CH0, CH1);
    repeat (8) cycle();
    pulse(2'b11, CH0, CH1);
    cycle();
    #2 reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_level", fifo_level, 0);
    chk("abort_frames", frames_done, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_finished", finished, 0);
    model_reset();
    got.delete();
    #1 reset = 1'b0;

    // Clear in the middle of a frame together with a valid result.
    pulse(2'b11, CH0, CH1);
    cycle();
    clear = 1'b1; res_valid = 2'b11;
    cycle();
    chk("clr_level", fifo_level, 0);
    chk("clr_overflow", overflow, 0);
    clear = 1'b0; res_valid = '0;
    cycle();
    chk("clr_no_capture", fifo_level, 0);

    // Randomised traffic against the model.
    do_clear();
    for (int t = 0; t < 4000; t++) begin
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      res_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      res_valid = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      clear     = ($urandom_range(0, 299) == 0);
      if (clear) frame_limit = 16'($urandom_range(0, 5));
      cycle();
    end
    clear = 1'b0; res_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_stream_packer.md
Name: result_stream_packer

Overview:
- Generalised result-capture block between the lock-in processing datapath and the processor-side streaming FIFO interface.
- Captures a snapshot of N_CH result channels, each RESULT_W bits wide, whenever any channel flags a valid result.
- Serialises each snapshot into 32-bit words, low word first, into an internal first-word-fall-through buffer.
- Drains the buffer through a ready/valid stream; supports a programmable frame limit with a finished flag, and a sticky overflow flag for dropped results.

Parameters:
- N_CH, 2, number of result channels (1..8).
- RESULT_W, 64, width of each channel result; multiple of 32, range 32..128.
- FIFO_DEPTH, 256, buffer depth in 32-bit words; power of 2, at least 4.
- CNT_W, 16, width of the frame counter and of frame_limit.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable from control.
- clear  in  1  synchronous soft clear from control.
- frame_limit  in  CNT_W  frames to capture before finishing; 0 = unlimited.
- res_data  in  N_CH*RESULT_W  channel c occupies bits [c*RESULT_W +: RESULT_W].
- res_valid  in  N_CH  per-channel result-valid strobe.
- out_data  out  32  stream word.
- out_valid  out  1  stream word available.
- out_ready  in  1  consumer accepts word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
- frames_done  out  CNT_W  completed frames; saturates at all-ones.
- overflow  out  1  sticky; a valid result was dropped.
- finished  out  1  frame_limit reached.

Behaviour:
- Reset values: all outputs 0, state IDLE, buffer empty. Reset takes effect asynchronously, including mid-frame.
- clear:
  - Same effect as reset, applied on the next clk edge.
  - Has priority over every other event in that cycle, including capture, push and pop.
- WPC = RESULT_W/32 words per channel.
- State IDLE:
  - Capture condition: enable && !finished && |res_valid.
  - On capture, latch res_data into the snapshot and res_valid into mask; go to SER with channel index = lowest set mask bit and word index = 0.
- State SER:
  - Each cycle where the buffer is not full, push snapshot[ch][word*32 +: 32] and advance.
  - Advance order: word first, then the next set mask bit in ascending channel order.
  - Unset channels are skipped with zero cycles lost.
  - When the buffer is full, stall and hold the current indices; no data is lost.
  - After the last word is pushed, go to DONE.
- State DONE (one cycle):
  - frames_done increments, saturating.
  - If frame_limit != 0 and the new count == frame_limit, set finished (sticky until reset or clear).
  - Return to IDLE.
  - A capture condition in this cycle is not accepted; it counts as a drop.
- Drops: any |res_valid while in SER or DONE, with enable=1 and finished=0, sets overflow; that result is discarded.
- enable gating:
  - enable only gates new captures.
  - Deasserting enable mid-frame does not abort; the frame always completes, so the stream never carries partial frames.
- While finished=1, res_valid is ignored: no capture and no overflow.
- Latency, with no stall: first word of a frame is pushed 1 cycle after capture; out_valid rises 1 cycle after the push into an empty buffer. Minimum frame period is WPC*popcount(mask)+2 cycles.
- Buffer:
  - out_valid = !empty; out_data is the head word.
  - Pop on out_valid && out_ready.
  - full is evaluated before the same-cycle pop, so a push is refused when full even if a pop occurs that cycle.
  - Simultaneous push and pop when not full leaves fifo_level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Widths: fifo_level counts 0..FIFO_DEPTH inclusive. No arithmetic on data; bit slicing only.

Decomposition:
- Shared package lockin_stream_pkg:
  - WORD_W = 32.
  - State enum {IDLE, SER, DONE}.
  - Function words_per_channel(RESULT_W).
- One sub-module: sync_fwft_fifo (parameters WIDTH, DEPTH), with ports push, pop, din, dout, empty, full, level, and synchronous clear.
- Snapshot, sequencer and counters stay in the top module.

Test Plan:
- Full frame: N_CH=2, RESULT_W=64. ch0=0x1111_2222_3333_4444, ch1=0xAAAA_BBBB_CCCC_DDDD, both valid, out_ready=1 -> out_data sequence 0x33334444, 0x11112222, 0xCCCCDDDD, 0xAAAABBBB; frames_done=1; overflow=0.
- Partial mask: only res_valid[1] set -> exactly 2 words, 0xCCCCDDDD then 0xAAAABBBB; first word pushed 1 cycle after capture.
- Frame limit: frame_limit=3, both channels valid every 8 cycles for 10 pulses -> 12 words streamed; finished=1 after the third DONE; frames_done=3; overflow=0.
- Back-pressure: FIFO_DEPTH=8, out_ready=0, 3 captures spaced 12 cycles apart -> fifo_level=8, SER stalls. Then out_ready=1 -> all 12 words drain in order, no loss, frames_done=3.
- Drop: a second res_valid pulse 1 cycle after capture (during SER) -> overflow=1, only one frame streamed; overflow stays 1 until clear.
- Abort: reset pulsed mid-SER -> all outputs 0 immediately. Separately, clear asserted mid-SER together with res_valid -> fifo_level=0 and state IDLE next cycle; no capture, no overflow.
